// File: rtl/inst_ram_boot_loader_pkg.sv
// Shared types and helpers for the instruction RAM boot loader.
// Holds the default CPU reset vector, the FSM state encoding and the word address helper.
package inst_ram_boot_loader_pkg;

   localparam logic [31:0] PC_INITIAL_DEFAULT = 32'hbfc00000;
   localparam int          TIMER_W            = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      GAP,
      HOLD,
      RUN,
      ERROR
   } state_t;

   function automatic logic [31:0] word_address(input logic [31:0] base, input logic [31:0] index);
      return base + (index << 2);
   endfunction

endpackage

// File: rtl/inst_ram_boot_loader_cycle_timer.sv
// Loadable down-counter with a zero flag; one instance times both the inter-word gap
// and the CPU reset hold window.
module inst_ram_boot_loader_cycle_timer
   import inst_ram_boot_loader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   output logic               zero
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - TIMER_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/inst_ram_boot_loader.sv
// Holds the CPU in reset/debug, streams an image into instruction RAM, then releases the CPU.
//
//   state | meaning
//   IDLE  | after reset, CPU held, waiting for start
//   LOAD  | src_ready high, waiting for an image word
//   WRITE | one-cycle write strobe for the captured word
//   GAP   | idle spacing between writes
//   HOLD  | image complete, CPU still held in reset for the hold window
//   RUN   | CPU released; start reloads
//   ERROR | image overflowed capacity; CPU held, start reloads
module inst_ram_boot_loader
   import inst_ram_boot_loader_pkg::*;
#(
   parameter logic [31:0] PC_INITIAL  = PC_INITIAL_DEFAULT,
   parameter int          MAX_WORDS   = 1024,
   parameter int          GAP_CYCLES  = 1,
   parameter int          HOLD_CYCLES = 70,
   parameter int          CNT_W       = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             src_valid,
   input  logic [31:0]      src_data,
   input  logic             src_last,
   output logic             src_ready,
   output logic             inst_ram_write_enable,
   output logic [31:0]      inst_ram_write_data,
   output logic [31:0]      inst_ram_write_address,
   output logic             cpu_reset,
   output logic             debug,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] words_loaded
);

   localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_WORDS);
   localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam bit                 GAP_EN    = (GAP_CYCLES > 0);

   state_t             state, state_next;
   logic               cap_last, last_next;
   logic [CNT_W-1:0]   wl_next;
   logic               we_next;
   logic [31:0]        wdata_next, waddr_next;
   logic               ready_next, busy_next, done_next, error_next, hold_cpu_next;
   logic               timer_load, timer_zero;
   logic [TIMER_W-1:0] timer_value;

   inst_ram_boot_loader_cycle_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .zero       (timer_zero)
   );

   always_comb begin
      state_next  = state;
      last_next   = cap_last;
      wl_next     = words_loaded;
      we_next     = 1'b0;
      wdata_next  = inst_ram_write_data;
      waddr_next  = inst_ram_write_address;
      timer_load  = 1'b0;
      timer_value = GAP_LOAD;

      case (state)
         IDLE, RUN, ERROR: begin
            if (start) begin
               state_next = LOAD;
               wl_next    = '0;
            end
         end
         LOAD: begin
            if (src_valid && src_ready) begin
               if (words_loaded == MAX_CNT) begin
                  state_next = ERROR;
               end else begin
                  state_next = WRITE;
                  last_next  = src_last;
                  we_next    = 1'b1;
                  wdata_next = src_data;
                  waddr_next = word_address(PC_INITIAL, 32'(words_loaded));
               end
            end
         end
         WRITE: begin
            wl_next = words_loaded + CNT_W'(1);
            // The final word has no following write to space out, so the hold
            // window starts right after its strobe.
            if (cap_last) begin
               state_next  = HOLD;
               timer_load  = 1'b1;
               timer_value = HOLD_LOAD;
            end else if (GAP_EN) begin
               state_next = GAP;
               timer_load = 1'b1;
            end else begin
               state_next = LOAD;
            end
         end
         GAP: begin
            if (timer_zero) state_next = LOAD;
         end
         HOLD: begin
            if (timer_zero) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase

      if (state_next == HOLD) begin
         wdata_next = '0;
         waddr_next = PC_INITIAL;
      end

      ready_next    = (state_next == LOAD);
      busy_next     = (state_next == LOAD) || (state_next == WRITE) ||
                      (state_next == GAP)  || (state_next == HOLD);
      done_next     = (state_next == RUN);
      hold_cpu_next = (state_next != RUN);
      error_next    = (state_next == ERROR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                  <= IDLE;
         cap_last               <= 1'b0;
         words_loaded           <= '0;
         inst_ram_write_enable  <= 1'b0;
         inst_ram_write_data    <= '0;
         inst_ram_write_address <= PC_INITIAL;
         src_ready              <= 1'b0;
         cpu_reset              <= 1'b1;
         debug                  <= 1'b1;
         busy                   <= 1'b0;
         done                   <= 1'b0;
         error                  <= 1'b0;
      end else begin
         state                  <= state_next;
         cap_last               <= last_next;
         words_loaded           <= wl_next;
         inst_ram_write_enable  <= we_next;
         inst_ram_write_data    <= wdata_next;
         inst_ram_write_address <= waddr_next;
         src_ready              <= ready_next;
         cpu_reset              <= hold_cpu_next;
         debug                  <= hold_cpu_next;
         busy                   <= busy_next;
         done                   <= done_next;
         error                  <= error_next;
      end
   end

endmodule

// File: tb/tb_inst_ram_boot_loader.sv
// Scoreboard bench for the boot loader: three instances cover the default timing,
// back-to-back writes and image overflow.
module tb_inst_ram_boot_loader;

   localparam logic [31:0] PC0 = 32'hbfc00000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int n_cmp = 0;
   int n_err = 0;

   // instance A: GAP=1, HOLD=70, MAX=1024
   logic a_rst, a_start, a_valid, a_last, a_ready, a_we, a_cpu_rst, a_debug, a_busy, a_done, a_error;
   logic [31:0] a_data, a_wdata, a_waddr;
   logic [10:0] a_wl;
   // instance B: GAP=0, HOLD=3
   logic b_rst, b_start, b_valid, b_last, b_ready, b_we, b_cpu_rst, b_debug, b_busy, b_done, b_error;
   logic [31:0] b_data, b_wdata, b_waddr;
   logic [10:0] b_wl;
   // instance C: MAX=4, GAP=1, HOLD=4
   logic c_rst, c_start, c_valid, c_last, c_ready, c_we, c_cpu_rst, c_debug, c_busy, c_done, c_error;
   logic [31:0] c_data, c_wdata, c_waddr;
   logic [2:0]  c_wl;

   inst_ram_boot_loader #(.PC_INITIAL(PC0), .MAX_WORDS(1024), .GAP_CYCLES(1), .HOLD_CYCLES(70), .CNT_W(11)) dut_a (
      .clk(clk), .reset(a_rst), .start(a_start), .src_valid(a_valid), .src_data(a_data), .src_last(a_last),
      .src_ready(a_ready), .inst_ram_write_enable(a_we), .inst_ram_write_data(a_wdata),
      .inst_ram_write_address(a_waddr), .cpu_reset(a_cpu_rst), .debug(a_debug), .busy(a_busy),
      .done(a_done), .error(a_error), .words_loaded(a_wl));

   inst_ram_boot_loader #(.PC_INITIAL(PC0), .MAX_WORDS(1024), .GAP_CYCLES(0), .HOLD_CYCLES(3), .CNT_W(11)) dut_b (
      .clk(clk), .reset(b_rst), .start(b_start), .src_valid(b_valid), .src_data(b_data), .src_last(b_last),
      .src_ready(b_ready), .inst_ram_write_enable(b_we), .inst_ram_write_data(b_wdata),
      .inst_ram_write_address(b_waddr), .cpu_reset(b_cpu_rst), .debug(b_debug), .busy(b_busy),
      .done(b_done), .error(b_error), .words_loaded(b_wl));

   inst_ram_boot_loader #(.PC_INITIAL(PC0), .MAX_WORDS(4), .GAP_CYCLES(1), .HOLD_CYCLES(4), .CNT_W(3)) dut_c (
      .clk(clk), .reset(c_rst), .start(c_start), .src_valid(c_valid), .src_data(c_data), .src_last(c_last),
      .src_ready(c_ready), .inst_ram_write_enable(c_we), .inst_ram_write_data(c_wdata),
      .inst_ram_write_address(c_waddr), .cpu_reset(c_cpu_rst), .debug(c_debug), .busy(c_busy),
      .done(c_done), .error(c_error), .words_loaded(c_wl));

   logic [63:0] a_exp[$], b_exp[$], c_exp[$];
   int          a_strobes[$], b_strobes[$], c_strobes[$];

   // scoreboards: every observed write strobe pops the oldest expected {address, data}
   always @(negedge clk) begin
      logic [63:0] e;
      if (a_we === 1'b1) begin
         a_strobes.push_back(cycle);
         n_cmp++;
         if (a_exp.size() == 0) begin
            n_err++;
            $display("FAIL a_write unexpected: got addr=%h data=%h, want no write", a_waddr, a_wdata);
         end else begin
            e = a_exp.pop_front();
            if ({a_waddr, a_wdata} !== e) begin
               n_err++;
               $display("FAIL a_write: got addr=%h data=%h, want addr=%h data=%h", a_waddr, a_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [63:0] e;
      if (b_we === 1'b1) begin
         b_strobes.push_back(cycle);
         n_cmp++;
         if (b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b_ready_in_write: got %b, want 0", b_ready);
         end
         n_cmp++;
         if (b_exp.size() == 0) begin
            n_err++;
            $display("FAIL b_write unexpected: got addr=%h data=%h, want no write", b_waddr, b_wdata);
         end else begin
            e = b_exp.pop_front();
            if ({b_waddr, b_wdata} !== e) begin
               n_err++;
               $display("FAIL b_write: got addr=%h data=%h, want addr=%h data=%h", b_waddr, b_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [63:0] e;
      if (c_we === 1'b1) begin
         c_strobes.push_back(cycle);
         n_cmp++;
         if (c_exp.size() == 0) begin
            n_err++;
            $display("FAIL c_write unexpected: got addr=%h data=%h, want no write", c_waddr, c_wdata);
         end else begin
            e = c_exp.pop_front();
            if ({c_waddr, c_wdata} !== e) begin
               n_err++;
               $display("FAIL c_write: got addr=%h data=%h, want addr=%h data=%h", c_waddr, c_wdata, e[63:32], e[31:0]);
            end
         end
      end
   end

   // source drivers: called just after a negedge, return at the negedge after the handshake
   task automatic a_push(input logic [31:0] d, input logic l, input int idx);
      int t = 0;
      a_valid = 1'b1; a_data = d; a_last = l;
      while (a_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 300) begin
         n_err++;
         $display("FAIL a_handshake_timeout word %0d: got ready=%b, want 1", idx, a_ready);
      end else begin
         a_exp.push_back({PC0 + 32'(idx) * 32'd4, d});
      end
      @(negedge clk);
      a_valid = 1'b0; a_last = 1'b0;
   endtask

   task automatic b_push(input logic [31:0] d, input logic l, input int idx);
      int t = 0;
      b_valid = 1'b1; b_data = d; b_last = l;
      while (b_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 300) begin
         n_err++;
         $display("FAIL b_handshake_timeout word %0d: got ready=%b, want 1", idx, b_ready);
      end else begin
         b_exp.push_back({PC0 + 32'(idx) * 32'd4, d});
      end
      @(negedge clk);
      // valid stays high: the next push re-drives it in the same time step
   endtask

   task automatic c_push(input logic [31:0] d, input logic l, input int idx, input bit wr);
      int t = 0;
      c_valid = 1'b1; c_data = d; c_last = l;
      while (c_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 300) begin
         n_err++;
         $display("FAIL c_handshake_timeout word %0d: got ready=%b, want 1", idx, c_ready);
      end else if (wr) begin
         c_exp.push_back({PC0 + 32'(idx) * 32'd4, d});
      end
      @(negedge clk);
      c_valid = 1'b0; c_last = 1'b0;
   endtask

   // waits for cpu_reset to drop on A and checks it fell 71 samples after the last strobe
   // (one strobe cycle plus 70 held cycles)
   task automatic a_wait_release(input string name);
      int t = 0;
      while (a_cpu_rst !== 1'b0 && t < 500) begin @(negedge clk); t++; end
      n_cmp++;
      if (t >= 500 || a_strobes.size() == 0) begin
         n_err++;
         $display("FAIL %s release_timeout: got cpu_reset=%b, want 0", name, a_cpu_rst);
      end else if (cycle - a_strobes[$] != 71) begin
         n_err++;
         $display("FAIL %s hold_time: got %0d cycles strobe-to-release, want 71", name, cycle - a_strobes[$]);
      end
   endtask

   task automatic test_reset();
      a_rst = 0; b_rst = 0; c_rst = 0;
      {a_start, a_valid, a_last} = '0; a_data = '0;
      {b_start, b_valid, b_last} = '0; b_data = '0;
      {c_start, c_valid, c_last} = '0; c_data = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({a_cpu_rst, a_debug, a_we, a_ready, a_busy, a_done, a_error} !== 7'b1100000) begin
         n_err++;
         $display("FAIL reset_flags: got %b, want 1100000",
                  {a_cpu_rst, a_debug, a_we, a_ready, a_busy, a_done, a_error});
      end
      n_cmp++;
      if (a_wdata !== 32'd0 || a_waddr !== PC0 || a_wl !== 11'd0) begin
         n_err++;
         $display("FAIL reset_data: got data=%h addr=%h wl=%0d, want 0 %h 0", a_wdata, a_waddr, a_wl, PC0);
      end
      n_cmp++;
      if ({b_cpu_rst, b_ready, c_cpu_rst, c_error, c_wl} !== 7'b1010000) begin
         n_err++;
         $display("FAIL reset_bc: got %b, want 1010000", {b_cpu_rst, b_ready, c_cpu_rst, c_error, c_wl});
      end
      a_rst = 1; b_rst = 1; c_rst = 1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({a_cpu_rst, a_debug, a_ready, a_busy, a_done} !== 5'b11000) begin
         n_err++;
         $display("FAIL idle_hold: got %b, want 11000", {a_cpu_rst, a_debug, a_ready, a_busy, a_done});
      end
   endtask

   task automatic test_load_13();
      int bad = 0;
      a_strobes.delete();
      a_start = 1; @(negedge clk); a_start = 0;
      n_cmp++;
      if ({a_busy, a_ready, a_cpu_rst, a_debug, a_done} !== 5'b11110 || a_wl !== 11'd0) begin
         n_err++;
         $display("FAIL load_entry: got %b wl=%0d, want 11110 wl=0", {a_busy, a_ready, a_cpu_rst, a_debug, a_done}, a_wl);
      end
      for (int i = 0; i < 13; i++) a_push($urandom, i == 12, i);
      a_wait_release("load13");
      n_cmp++;
      if (a_strobes.size() != 13) begin
         n_err++;
         $display("FAIL load13_count: got %0d strobes, want 13", a_strobes.size());
      end
      for (int i = 1; i < a_strobes.size(); i++) if (a_strobes[i] - a_strobes[i-1] != 3) bad++;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL load13_spacing: got %0d gaps not 3 cycles, want 0", bad);
      end
      n_cmp++;
      if ({a_done, a_debug, a_busy, a_error} !== 4'b1000 || a_wl !== 11'd13 || a_exp.size() != 0) begin
         n_err++;
         $display("FAIL load13_final: got done/debug/busy/err=%b wl=%0d pending=%0d, want 1000 13 0",
                  {a_done, a_debug, a_busy, a_error}, a_wl, a_exp.size());
      end
   endtask

   task automatic test_reset_mid_gap();
      a_start = 1; @(negedge clk); a_start = 0;
      for (int i = 0; i < 3; i++) a_push(32'h1000 + 32'(i), 1'b0, i);
      @(negedge clk);
      n_cmp++;
      if (a_we !== 1'b0 || a_ready !== 1'b0 || a_waddr !== PC0 + 32'd8 || a_wdata !== 32'h1002) begin
         n_err++;
         $display("FAIL gap_hold: got we=%b ready=%b addr=%h data=%h, want 0 0 %h 00001002",
                  a_we, a_ready, a_waddr, a_wdata, PC0 + 32'd8);
      end
      #1 a_rst = 0;
      #1;
      n_cmp++;
      if ({a_cpu_rst, a_debug, a_we, a_ready, a_busy, a_done, a_error} !== 7'b1100000 ||
          a_waddr !== PC0 || a_wdata !== 32'd0 || a_wl !== 11'd0) begin
         n_err++;
         $display("FAIL async_reset: got flags=%b addr=%h data=%h wl=%0d, want 1100000 %h 0 0",
                  {a_cpu_rst, a_debug, a_we, a_ready, a_busy, a_done, a_error}, a_waddr, a_wdata, a_wl, PC0);
      end
      @(negedge clk); a_rst = 1;
      @(negedge clk);
      a_strobes.delete();
      a_start = 1; @(negedge clk); a_start = 0;
      a_push(32'h2000, 1'b0, 0);
      a_push(32'h2001, 1'b1, 1);
      a_wait_release("restart");
      n_cmp++;
      if (a_wl !== 11'd2 || a_done !== 1'b1 || a_exp.size() != 0) begin
         n_err++;
         $display("FAIL restart_final: got wl=%0d done=%b pending=%0d, want 2 1 0", a_wl, a_done, a_exp.size());
      end
   endtask

   task automatic test_restart_from_run();
      a_start = 1; @(negedge clk); a_start = 0;
      n_cmp++;
      if ({a_cpu_rst, a_debug, a_done, a_busy} !== 4'b1101) begin
         n_err++;
         $display("FAIL run_restart: got cpu_reset/debug/done/busy=%b, want 1101", {a_cpu_rst, a_debug, a_done, a_busy});
      end
      a_push(32'hcafef00d, 1'b1, 0);
      a_wait_release("one_word");
      n_cmp++;
      if (a_wl !== 11'd1 || a_done !== 1'b1 || a_exp.size() != 0) begin
         n_err++;
         $display("FAIL one_word_final: got wl=%0d done=%b pending=%0d, want 1 1 0", a_wl, a_done, a_exp.size());
      end
   endtask

   task automatic test_ignored_inputs();
      int n0;
      a_start = 1; @(negedge clk); a_start = 0;
      n0 = a_strobes.size();
      for (int i = 0; i < 6; i++) begin
         a_push(32'h5000 + 32'(i * 7), i == 5, i);
         if (i < 5) begin
            // WRITE then GAP: junk on the source and start pulsed, none of it may be taken
            a_valid = 1; a_data = 32'hdeadbeef; a_last = 1; a_start = 1;
            @(negedge clk);
            a_valid = 0;
            #2 a_valid = 1;
            @(negedge clk);
            a_valid = 0; a_last = 0;
         end
      end
      for (int k = 0; k < 10; k++) begin
         a_start = (k % 2 == 0); a_valid = (k % 3 == 0); a_data = 32'hbad0bad0; a_last = 1;
         @(negedge clk);
      end
      a_start = 0; a_valid = 0; a_last = 0;
      a_wait_release("ignore");
      n_cmp++;
      if (a_strobes.size() - n0 != 6 || a_wl !== 11'd6 || a_exp.size() != 0) begin
         n_err++;
         $display("FAIL ignore_final: got strobes=%0d wl=%0d pending=%0d, want 6 6 0",
                  a_strobes.size() - n0, a_wl, a_exp.size());
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      int t = 0;
      b_start = 1; @(negedge clk); b_start = 0;
      for (int i = 0; i < 8; i++) b_push(32'h0a000000 + 32'($urandom_range(0, 65535)), i == 7, i);
      b_valid = 0; b_last = 0;
      while (b_done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      for (int i = 1; i < b_strobes.size(); i++) if (b_strobes[i] - b_strobes[i-1] != 2) bad++;
      n_cmp++;
      if (b_strobes.size() != 8 || bad != 0) begin
         n_err++;
         $display("FAIL b2b_spacing: got %0d strobes with %0d gaps not 2, want 8 and 0", b_strobes.size(), bad);
      end
      n_cmp++;
      if (b_done !== 1'b1 || b_cpu_rst !== 1'b0 || b_wl !== 11'd8 || b_exp.size() != 0) begin
         n_err++;
         $display("FAIL b2b_final: got done=%b cpu_reset=%b wl=%0d pending=%0d, want 1 0 8 0",
                  b_done, b_cpu_rst, b_wl, b_exp.size());
      end
   endtask

   task automatic test_overflow();
      int t = 0;
      c_start = 1; @(negedge clk); c_start = 0;
      for (int i = 0; i < 5; i++) c_push(32'h7700 + 32'(i), 1'b0, i, i < 4);
      n_cmp++;
      if ({c_error, c_cpu_rst, c_debug, c_busy, c_ready, c_done} !== 6'b111000 || c_wl !== 3'd4) begin
         n_err++;
         $display("FAIL overflow_state: got err/cpu/dbg/busy/rdy/done=%b wl=%0d, want 111000 4",
                  {c_error, c_cpu_rst, c_debug, c_busy, c_ready, c_done}, c_wl);
      end
      repeat (5) @(negedge clk);
      n_cmp++;
      if (c_strobes.size() != 4 || c_error !== 1'b1 || c_cpu_rst !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_sticky: got strobes=%0d error=%b cpu_reset=%b, want 4 1 1",
                  c_strobes.size(), c_error, c_cpu_rst);
      end
      c_start = 1; @(negedge clk); c_start = 0;
      n_cmp++;
      if ({c_error, c_ready, c_busy} !== 3'b011 || c_wl !== 3'd0) begin
         n_err++;
         $display("FAIL overflow_restart: got err/rdy/busy=%b wl=%0d, want 011 0", {c_error, c_ready, c_busy}, c_wl);
      end
      c_push(32'h88888888, 1'b1, 0, 1'b1);
      while (c_done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      n_cmp++;
      if (c_done !== 1'b1 || c_wl !== 3'd1 || c_exp.size() != 0) begin
         n_err++;
         $display("FAIL overflow_reload: got done=%b wl=%0d pending=%0d, want 1 1 0", c_done, c_wl, c_exp.size());
      end
   endtask

   initial begin
      test_reset();
      test_load_13();
      test_reset_mid_gap();
      test_restart_from_run();
      test_ignored_inputs();
      test_back_to_back();
      test_overflow();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want bench to finish");
      $fatal(1, "watchdog");
   end

endmodule
